// File: rtl/dht_reader_gen2.sv
// dht_reader_gen2
//   Single-wire reader for DHT11/DHT22 humidity/temperature sensors. Issues the
//   host start pulse (on a manual trigger or from the auto-poll timer), then
//   receives the sensor response and the 40-bit frame. The checksum is verified
//   before the raw 16-bit humidity/temperature words are updated.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   start         1-cycle trigger, ignored while busy
//   dht_io        sensor line; pulled to 0 by the host or left high-Z
//   hum, temp     {byte0,byte1} / {byte2,byte3} of the last good frame
//   valid         1-cycle pulse, hum/temp just updated
//   err_timeout   1-cycle pulse, frame aborted because a line level lasted too long
//   err_checksum  1-cycle pulse, frame complete but checksum wrong
//   busy          high from leaving IDLE until the FSM is back in IDLE
//   state_dbg     FSM state (ABORT reports as 7, shared with CHECK)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line released, waiting for start or poll expiry
// START_LOW | host holds the line low (18 ms DHT11 / 1 ms DHT22)
// RELEASE   | line released, waiting for the sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low lead-in of a data bit
// BIT_HIGH  | high phase of a data bit; its length selects 0 or 1
// CHECK     | one cycle, checksum compare and output update
// ABORT     | one cycle, timeout report

module dht_reader_gen2 #(
    parameter int CLK_HZ     = 50_000_000,
    parameter bit DHT22_MODE = 1'b0,
    parameter int POLL_MS    = 2000,
    parameter int TIMEOUT_US = 200,
    parameter int BIT1_US    = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    inout  wire         dht_io,
    output logic [15:0] hum,
    output logic [15:0] temp,
    output logic        valid,
    output logic        err_timeout,
    output logic        err_checksum,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam int unsigned US        = CLK_HZ / 1_000_000;
    localparam logic [31:0] START_CYC = 32'(DHT22_MODE ? 1000 * US : 18000 * US);
    localparam logic [31:0] TO_CYC    = 32'(TIMEOUT_US * US);
    localparam logic [31:0] BIT1_CYC  = 32'(BIT1_US * US);

    // Poll period can exceed 32 bits at high clock rates, so size it from the product.
    localparam longint POLL_CYC  = longint'(POLL_MS) * 64'd1000 * longint'(US);
    localparam int     PW        = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
    localparam bit     POLL_EN   = (POLL_MS != 0);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_LOW = 4'd1,
        RELEASE   = 4'd2,
        RESP_LOW  = 4'd3,
        RESP_HIGH = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        CHECK     = 4'd7,
        ABORT     = 4'd8
    } state_t;

    state_t        state;
    logic [2:0]    sync;
    logic          drive_low;
    logic [31:0]   timer;
    logic [PW-1:0] poll_cnt;
    logic [5:0]    bit_cnt;
    logic [39:0]   shift;
    logic          rise;
    logic          fall;
    logic          poll_hit;
    logic          timeout_hit;
    logic [7:0]    sum;

    assign dht_io = drive_low ? 1'b0 : 1'bz;

    // sync[1] is the synchronised level, sync[2] its previous value.
    assign rise        = sync[1] & ~sync[2];
    assign fall        = ~sync[1] & sync[2];
    assign poll_hit    = POLL_EN && (poll_cnt == POLL_LAST);
    assign timeout_hit = (timer == TO_CYC - 32'd1);
    assign sum         = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];
    assign state_dbg   = (state == ABORT) ? 3'd7 : state[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], dht_io};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drive_low    <= 1'b0;
            timer        <= '0;
            poll_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            hum          <= '0;
            temp         <= '0;
            valid        <= 1'b0;
            err_timeout  <= 1'b0;
            err_checksum <= 1'b0;
            busy         <= 1'b0;
        end else begin
            valid        <= 1'b0;
            err_timeout  <= 1'b0;
            err_checksum <= 1'b0;
            case (state)
                IDLE: begin
                    // Poll counter only runs while idle, so the period is measured
                    // from the end of one transaction to the start of the next.
                    if (start || poll_hit) begin
                        state     <= START_LOW;
                        drive_low <= 1'b1;
                        busy      <= 1'b1;
                        timer     <= '0;
                        poll_cnt  <= '0;
                        bit_cnt   <= '0;
                    end else if (POLL_EN) begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                START_LOW: begin
                    if (timer == START_CYC - 32'd1) begin
                        drive_low <= 1'b0;
                        timer     <= '0;
                        state     <= RELEASE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                RELEASE, RESP_HIGH: begin
                    if (fall) begin
                        timer <= '0;
                        state <= (state == RELEASE) ? RESP_LOW : BIT_LOW;
                    end else if (timeout_hit) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                RESP_LOW, BIT_LOW: begin
                    if (rise) begin
                        timer <= '0;
                        state <= (state == RESP_LOW) ? RESP_HIGH : BIT_HIGH;
                    end else if (timeout_hit) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                BIT_HIGH: begin
                    if (fall) begin
                        shift <= {shift[38:0], (timer > BIT1_CYC)};
                        timer <= '0;
                        if (bit_cnt == 6'd39) begin
                            state <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= BIT_LOW;
                        end
                    end else if (timeout_hit) begin
                        state <= ABORT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                CHECK: begin
                    if (shift[7:0] == sum) begin
                        hum   <= shift[39:24];
                        temp  <= shift[23:8];
                        valid <= 1'b1;
                    end else begin
                        err_checksum <= 1'b1;
                    end
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                ABORT: begin
                    err_timeout <= 1'b1;
                    bit_cnt     <= '0;
                    timer       <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    drive_low <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_reader_gen2.sv
// tb_dht_reader_gen2
//   Directed bench for dht_reader_gen2 at 1 MHz (1 cycle = 1 us).
//   u_dut  : DHT22 start pulse, 5 ms auto-poll, sensor model on dht_io.
//   u_dut11: DHT11 start pulse, no auto-poll, nothing attached to its line.
//   Ports: none.

module tb_dht_reader_gen2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start11 = 1'b0;

    wire  dht_io;
    wire  dht11_io;
    logic sensor_low = 1'b0;

    logic [15:0] hum, temp, hum11, temp11;
    logic        valid, err_timeout, err_checksum, busy;
    logic        valid11, err_timeout11, err_checksum11, busy11;
    logic [2:0]  state_dbg, state_dbg11;

    logic [39:0] frame = '0;
    int          bit_idx = -1;
    logic        in_high = 1'b0;
    logic        model_active = 1'b0;

    int tests = 0;
    int failed = 0;

    pullup (dht_io);
    pullup (dht11_io);
    assign dht_io = sensor_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht_reader_gen2 #(
        .CLK_HZ(1_000_000), .DHT22_MODE(1'b1), .POLL_MS(5), .TIMEOUT_US(200), .BIT1_US(40)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .dht_io(dht_io),
        .hum(hum), .temp(temp), .valid(valid), .err_timeout(err_timeout),
        .err_checksum(err_checksum), .busy(busy), .state_dbg(state_dbg)
    );

    dht_reader_gen2 #(
        .CLK_HZ(1_000_000), .DHT22_MODE(1'b0), .POLL_MS(0), .TIMEOUT_US(200), .BIT1_US(40)
    ) u_dut11 (
        .clk(clk), .rst(rst), .start(start11), .dht_io(dht11_io),
        .hum(hum11), .temp(temp11), .valid(valid11), .err_timeout(err_timeout11),
        .err_checksum(err_checksum11), .busy(busy11), .state_dbg(state_dbg11)
    );

    // Sensor model: answers any host low of at least 500 us with the current frame.
    initial begin
        int lowc;
        int idx;
        forever begin
            @(negedge clk);
            if (dht_io === 1'b0) begin
                lowc = 0;
                while (dht_io === 1'b0 && lowc < 30000) begin
                    @(negedge clk);
                    lowc++;
                end
                if (lowc >= 500) begin
                    model_active = 1'b1;
                    repeat (30) @(negedge clk);
                    sensor_low = 1'b1;
                    repeat (80) @(negedge clk);
                    sensor_low = 1'b0;
                    repeat (80) @(negedge clk);
                    for (int i = 0; i < 40; i++) begin
                        bit_idx = i;
                        idx = 39 - i;
                        sensor_low = 1'b1;
                        repeat (50) @(negedge clk);
                        sensor_low = 1'b0;
                        in_high = 1'b1;
                        repeat (frame[idx] ? 70 : 26) @(negedge clk);
                        in_high = 1'b0;
                    end
                    bit_idx = -1;
                    sensor_low = 1'b1;
                    repeat (50) @(negedge clk);
                    sensor_low = 1'b0;
                    model_active = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int nv, output int nc, output int nt, output bit ok);
        nv = 0; nc = 0; nt = 0; ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            nv += int'(valid);
            nc += int'(err_checksum);
            nt += int'(err_timeout);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_model();
        for (int k = 0; k < 8000 && model_active; k++) @(negedge clk);
    endtask

    initial begin
        int  n, m, nv, nc, nt;
        bit  ok;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hum", 32'(hum), 32'h0);
        check("rst_temp", 32'(temp), 32'h0);
        check("rst_pulses", {29'd0, valid, err_timeout, err_checksum}, 32'd0);
        check("rst_line", 32'(dht_io), 32'd1);

        // Auto-poll: first transaction exactly 5000 cycles after reset; bit threshold frame
        frame = {8'h55, 8'hAA, 8'h00, 8'h00, 8'hFF};
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            n++;
            if (state_dbg != 3'd0) break;
        end
        check("poll_delay", 32'(n), 32'd5000);
        check("poll_start_low", 32'(state_dbg), 32'd1);
        check("poll_busy", 32'(busy), 32'd1);
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle(nv, nc, nt, ok);
        check("poll_done", 32'(ok), 32'd1);
        check("poll_valid_cnt", 32'(nv), 32'd1);
        check("poll_err_cnt", 32'(nc + nt), 32'd0);
        check("thresh_hum", 32'(hum), 32'h55AA);
        check("thresh_temp", 32'(temp), 32'h0000);
        @(negedge clk);
        check("poll_valid_1cyc", 32'(valid), 32'd0);
        repeat (20) @(negedge clk);
        check("busy_start_ignored", 32'(state_dbg), 32'd0);

        // Good frame on manual start
        wait_model();
        frame = {8'h37, 8'h00, 8'h19, 8'h00, 8'h50};
        pulse_start();
        check("good_busy", 32'(busy), 32'd1);
        wait_idle(nv, nc, nt, ok);
        check("good_done", 32'(ok), 32'd1);
        check("good_valid_cnt", 32'(nv), 32'd1);
        check("good_err_cnt", 32'(nc + nt), 32'd0);
        check("good_hum", 32'(hum), 32'h3700);
        check("good_temp", 32'(temp), 32'h1900);

        // Bad checksum: outputs hold
        wait_model();
        frame = {8'h37, 8'h00, 8'h19, 8'h00, 8'h51};
        pulse_start();
        wait_idle(nv, nc, nt, ok);
        check("bad_done", 32'(ok), 32'd1);
        check("bad_cksum_cnt", 32'(nc), 32'd1);
        check("bad_valid_cnt", 32'(nv + nt), 32'd0);
        check("bad_hum", 32'(hum), 32'h3700);
        check("bad_temp", 32'(temp), 32'h1900);

        // Reset during BIT_HIGH of bit 12
        wait_model();
        frame = {8'h12, 8'h34, 8'h05, 8'h06, 8'h51};
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (bit_idx == 12 && in_high) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reached_bit12", 32'(ok), 32'd1);
        repeat (10) @(negedge clk);
        check("mid_bit_high", 32'(state_dbg), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hum", 32'(hum), 32'h0);
        check("mid_rst_temp", 32'(temp), 32'h0);
        check("mid_rst_line", 32'(dht_io), 32'd1);
        wait_model();
        pulse_start();
        wait_idle(nv, nc, nt, ok);
        check("after_rst_valid_cnt", 32'(nv), 32'd1);
        check("after_rst_hum", 32'(hum), 32'h1234);
        check("after_rst_temp", 32'(temp), 32'h0506);

        // DHT11 start pulse length and no-sensor timeout
        @(negedge clk);
        start11 = 1'b1;
        @(negedge clk);
        start11 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (dht11_io === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("dht11_line_low", 32'(ok), 32'd1);
        n = 0;
        for (int k = 0; k < 20000 && dht11_io === 1'b0; k++) begin
            n++;
            @(negedge clk);
        end
        check("dht11_start_low", 32'(n), 32'd18000);
        m = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            m++;
            if (err_timeout11) break;
        end
        check("timeout_delay", 32'(m >= 195 && m <= 210), 32'd1);
        check("timeout_pulse", 32'(err_timeout11), 32'd1);
        check("timeout_busy", 32'(busy11), 32'd0);
        check("timeout_state", 32'(state_dbg11), 32'd0);
        check("timeout_line", 32'(dht11_io), 32'd1);
        check("timeout_hum", 32'(hum11), 32'h0);
        @(negedge clk);
        check("timeout_1cyc", 32'(err_timeout11), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
